alto_next_address: RTL and testbench
====================================

// Module: alto_next_address
// PURPOSE
//  Microcode sequencer back end: consumes NEXT field, OR-ed dispatch modifiers and skip
//  from the F2 owners (emulator IR/BUSODD dispatch, etc.) and produces the microaddress
//  of the next instruction. Holds one saved MPC per task; performs deferred TASK switches.
// PARAMETERS
//  ADDR_W      10   microaddress width
//  TASKS       16   number of tasks / saved MPC slots
//  TASK_W      4    task number width (log2 TASKS)
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       synchronous reset, active-high
//  next_field_i     in   ADDR_W  NEXT field of current microinstruction
//  modifiers_i      in   ADDR_W  OR of all dispatch modifier sources (combinational)
//  skip_i           in   1       conditional skip; OR-ed into bit 0
//  stall_i          in   1       hold: no state changes this cycle
//  task_f1_i        in   1       current instruction has F1=TASK
//  next_task_i      in   TASK_W  highest-priority requesting task, sampled with task_f1_i
//  mpc_o            out  ADDR_W  address of microinstruction executing this cycle
//  current_task_o   out  TASK_W  task owning mpc_o
//  task_switched_o  out  1       1-cycle pulse: first cycle of a newly switched-in task
//  switch_pending_o out  1       TASK accepted, switch occurs after next instruction
// BEHAVIOUR
//  Reset (rst_i=1, overrides stall): saved_mpc[t]=t for all t; current_task_o=0;
//   mpc_o=0; pending=0; pending_task=0; task_switched_o=0. Mid-operation reset discards
//   pending switch and all saved addresses.
//  next_addr = next_field_i | modifiers_i | {0, skip_i}; pure OR, no carry, no wrap.
//  stall_i=1: every register holds; task_switched_o forced 0; task_f1_i ignored.
//  Non-stalled cycle, pending=0:
//   - mpc_o <= next_addr; saved_mpc[current] <= next_addr.
//   - if task_f1_i: pending <= 1; pending_task <= next_task_i.
//  Non-stalled cycle, pending=1 (instruction after the TASK one, still old task):
//   - saved_mpc[current] <= next_addr; pending <= 0.
//   - if pending_task != current: current_task_o <= pending_task;
//     mpc_o <= saved_mpc[pending_task]; task_switched_o <= 1.
//   - if pending_task == current: mpc_o <= next_addr; task_switched_o <= 0 (no switch).
//   - task_f1_i in this cycle is ignored (no back-to-back TASK acceptance).
//  task_switched_o = 1 only in the cycle after a real switch; otherwise 0.
//  Latency: next_addr appears on mpc_o one non-stalled clock after it is presented.
//  saved_mpc: TASKS x ADDR_W register file, one write port, one async read port;
//   read of pending_task and write of current in the same cycle never collide (differ).
//  switch_pending_o = pending (registered).
// TESTING
//  1 Reset, then NEXT=0x012, mods=0, skip=0, no stall -> mpc_o=0x012, task 0.
//  2 NEXT=0x100, mods=0x00B, skip=1 -> mpc_o=0x10B; NEXT=0x3FE|mods=0x001 -> 0x3FF.
//  3 Task 0 at NEXT=0x020 with task_f1_i, next_task_i=4; next instr NEXT=0x030 ->
//    mpc_o=0x004, current_task_o=4, task_switched_o=1 one cycle; saved_mpc[0]=0x030.
//    Later switch back to 0 -> mpc_o=0x030.
//  4 TASK accepted then stall_i=1 for 3 cycles -> mpc_o, task, pending frozen, pulse 0;
//    after stall release switch completes exactly as in 3.
//  5 TASK with next_task_i=current (0), NEXT=0x055 -> mpc_o=0x055, no pulse, pending clears.
//  6 rst_i asserted while pending=1 -> pending=0, mpc_o=0, task 0, saved_mpc[7]=7.

Source files
------------

// File: rtl/alto_next_address.sv
// Microcode sequencer back end: forms the next microaddress from NEXT | modifiers | skip,
// keeps one saved MPC per task and performs TASK switches one instruction late.
module alto_next_address #(
   parameter int ADDR_W = 10,
   parameter int TASKS  = 16,
   parameter int TASK_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] next_field_i,
   input  logic [ADDR_W-1:0] modifiers_i,
   input  logic              skip_i,
   input  logic              stall_i,
   input  logic              task_f1_i,
   input  logic [TASK_W-1:0] next_task_i,
   output logic [ADDR_W-1:0] mpc_o,
   output logic [TASK_W-1:0] current_task_o,
   output logic              task_switched_o,
   output logic              switch_pending_o
);

   logic [ADDR_W-1:0] mpc_q, mpc_d;
   logic [TASK_W-1:0] cur_task_q, cur_task_d;
   logic [TASK_W-1:0] pending_task_q, pending_task_d;
   logic              pending_q, pending_d;
   logic              switched_q, switched_d;
   logic [ADDR_W-1:0] saved_q [TASKS];
   logic [ADDR_W-1:0] saved_d [TASKS];
   logic [ADDR_W-1:0] next_addr_s;

   assign next_addr_s = next_field_i | modifiers_i | {{(ADDR_W-1){1'b0}}, skip_i};

   // Sequencing rules: normal advance, TASK acceptance, deferred switch, stall hold.
   always_comb begin
      mpc_d          = mpc_q;
      cur_task_d     = cur_task_q;
      pending_task_d = pending_task_q;
      pending_d      = pending_q;
      switched_d     = 1'b0;
      saved_d        = saved_q;
      if (stall_i) begin
         switched_d = 1'b0;
      end else if (!pending_q) begin
         mpc_d                = next_addr_s;
         saved_d[cur_task_q]  = next_addr_s;
         if (task_f1_i) begin
            pending_d      = 1'b1;
            pending_task_d = next_task_i;
         end else begin
            pending_d      = 1'b0;
         end
      end else begin
         // Instruction after TASK still belongs to the old task; the saved-slot read
         // targets a different task than the write whenever a switch actually happens.
         saved_d[cur_task_q] = next_addr_s;
         pending_d           = 1'b0;
         if (pending_task_q != cur_task_q) begin
            cur_task_d = pending_task_q;
            mpc_d      = saved_q[pending_task_q];
            switched_d = 1'b1;
         end else begin
            mpc_d      = next_addr_s;
            switched_d = 1'b0;
         end
      end
   end

   // State registers; reset seeds each task's saved MPC with its own task number.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mpc_q          <= {ADDR_W{1'b0}};
         cur_task_q     <= {TASK_W{1'b0}};
         pending_task_q <= {TASK_W{1'b0}};
         pending_q      <= 1'b0;
         switched_q     <= 1'b0;
         for (int i = 0; i < TASKS; i++) begin
            saved_q[i] <= ADDR_W'(i);
         end
      end else begin
         mpc_q          <= mpc_d;
         cur_task_q     <= cur_task_d;
         pending_task_q <= pending_task_d;
         pending_q      <= pending_d;
         switched_q     <= switched_d;
         saved_q        <= saved_d;
      end
   end

   assign mpc_o            = mpc_q;
   assign current_task_o   = cur_task_q;
   assign task_switched_o  = switched_q;
   assign switch_pending_o = pending_q;

endmodule

// File: tb/tb_alto_next_address.sv
// Self-checking bench for alto_next_address: directed scenarios plus a randomized run
// compared against a per-task behavioural model of the sequencer.
module tb_alto_next_address;

   logic       clk;
   logic       rst;
   logic [9:0] next_field;
   logic [9:0] modifiers;
   logic       skip;
   logic       stall;
   logic       task_f1;
   logic [3:0] next_task;
   logic [9:0] mpc;
   logic [3:0] cur_task;
   logic       switched;
   logic       pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: one resume address per task plus the deferred request.
   logic [9:0] m_resume [16];
   logic [9:0] m_mpc;
   logic [3:0] m_task;
   logic       m_pending;
   logic [3:0] m_req;
   logic       m_pulse;

   alto_next_address dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .next_field_i    (next_field),
      .modifiers_i     (modifiers),
      .skip_i          (skip),
      .stall_i         (stall),
      .task_f1_i       (task_f1),
      .next_task_i     (next_task),
      .mpc_o           (mpc),
      .current_task_o  (cur_task),
      .task_switched_o (switched),
      .switch_pending_o(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int t = 0; t < 16; t++) m_resume[t] = 10'(t);
      m_mpc = 10'h000; m_task = 4'h0; m_pending = 1'b0; m_req = 4'h0; m_pulse = 1'b0;
   endtask

   // Present one instruction's inputs, clock once, advance the model.
   task automatic cycle(input logic r, input logic [9:0] nf, input logic [9:0] md,
                        input logic sk, input logic st, input logic f1, input logic [3:0] nt);
      logic [9:0] target;
      rst = r; next_field = nf; modifiers = md; skip = sk; stall = st;
      task_f1 = f1; next_task = nt;
      target = nf | md | {9'd0, sk};
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else if (st) begin
         m_pulse = 1'b0;
      end else if (m_pending) begin
         m_resume[m_task] = target;
         m_pending = 1'b0;
         if (m_req != m_task) begin
            m_task  = m_req;
            m_mpc   = m_resume[m_req];
            m_pulse = 1'b1;
         end else begin
            m_mpc   = target;
            m_pulse = 1'b0;
         end
      end else begin
         m_resume[m_task] = target;
         m_mpc   = target;
         m_pulse = 1'b0;
         if (f1) begin
            m_pending = 1'b1;
            m_req     = nt;
         end
      end
   endtask

   task automatic test_reset();
      cycle(1'b1, 10'h3FF, 10'h000, 1'b0, 1'b1, 1'b1, 4'h9);
      n_checks++;
      if ({mpc, cur_task, switched, pending} !== {10'h000, 4'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: mpc=%h task=%h sw=%b pend=%b, required 000/0/0/0",
                  mpc, cur_task, switched, pending);
      end
   endtask

   task automatic test_next_addr();
      cycle(1'b0, 10'h012, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h012 || cur_task !== 4'h0) begin
         n_fail++; $display("FAIL plain_next: mpc=%h task=%h, required 012/0", mpc, cur_task);
      end
      cycle(1'b0, 10'h100, 10'h00B, 1'b1, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h10B) begin
         n_fail++; $display("FAIL or_skip: mpc=%h, required 10B", mpc);
      end
      cycle(1'b0, 10'h3FE, 10'h001, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h3FF) begin
         n_fail++; $display("FAIL or_top: mpc=%h, required 3FF", mpc);
      end
      cycle(1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h3FF) begin
         n_fail++; $display("FAIL no_carry: mpc=%h, required 3FF", mpc);
      end
   endtask

   task automatic test_task_switch();
      cycle(1'b0, 10'h020, 10'h000, 1'b0, 1'b0, 1'b1, 4'h4);
      n_checks++;
      if (mpc !== 10'h020 || pending !== 1'b1 || switched !== 1'b0) begin
         n_fail++; $display("FAIL accept: mpc=%h pend=%b sw=%b, required 020/1/0", mpc, pending, switched);
      end
      cycle(1'b0, 10'h030, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if ({mpc, cur_task, switched, pending} !== {10'h004, 4'h4, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL switch_in: mpc=%h task=%h sw=%b pend=%b, required 004/4/1/0",
                            mpc, cur_task, switched, pending);
      end
      cycle(1'b0, 10'h200, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h200 || switched !== 1'b0) begin
         n_fail++; $display("FAIL pulse_one: mpc=%h sw=%b, required 200/0", mpc, switched);
      end
      cycle(1'b0, 10'h201, 10'h000, 1'b0, 1'b0, 1'b1, 4'h0);
      cycle(1'b0, 10'h202, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if ({mpc, cur_task, switched} !== {10'h030, 4'h0, 1'b1}) begin
         n_fail++; $display("FAIL switch_back: mpc=%h task=%h sw=%b, required 030/0/1",
                            mpc, cur_task, switched);
      end
   endtask

   task automatic test_stall();
      cycle(1'b0, 10'h040, 10'h000, 1'b0, 1'b0, 1'b1, 4'h5);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 10'($urandom), 10'h000, 1'b1, 1'b1, 1'b1, 4'h9);
         n_checks++;
         if ({mpc, cur_task, switched, pending} !== {10'h040, 4'h0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL stall_hold%0d: mpc=%h task=%h sw=%b pend=%b, required 040/0/0/1",
                               i, mpc, cur_task, switched, pending);
         end
      end
      cycle(1'b0, 10'h050, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if ({mpc, cur_task, switched, pending} !== {10'h005, 4'h5, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL stall_release: mpc=%h task=%h sw=%b pend=%b, required 005/5/1/0",
                            mpc, cur_task, switched, pending);
      end
      cycle(1'b0, 10'h3AA, 10'h000, 1'b0, 1'b1, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h005 || switched !== 1'b0) begin
         n_fail++; $display("FAIL stall_kills_pulse: mpc=%h sw=%b, required 005/0", mpc, switched);
      end
      cycle(1'b0, 10'h060, 10'h000, 1'b0, 1'b0, 1'b1, 4'h0);
      cycle(1'b0, 10'h061, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h050 || cur_task !== 4'h0) begin
         n_fail++; $display("FAIL resume_0: mpc=%h task=%h, required 050/0", mpc, cur_task);
      end
   endtask

   task automatic test_same_task();
      cycle(1'b0, 10'h010, 10'h000, 1'b0, 1'b0, 1'b1, 4'h0);
      cycle(1'b0, 10'h055, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if ({mpc, cur_task, switched, pending} !== {10'h055, 4'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL same_task: mpc=%h task=%h sw=%b pend=%b, required 055/0/0/0",
                            mpc, cur_task, switched, pending);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b0, 10'h070, 10'h000, 1'b0, 1'b0, 1'b1, 4'h3);
      cycle(1'b0, 10'h071, 10'h000, 1'b0, 1'b0, 1'b1, 4'h6);
      n_checks++;
      if ({mpc, cur_task, pending} !== {10'h003, 4'h3, 1'b0}) begin
         n_fail++; $display("FAIL b2b_switch: mpc=%h task=%h pend=%b, required 003/3/0",
                            mpc, cur_task, pending);
      end
      cycle(1'b0, 10'h072, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if ({mpc, cur_task, switched, pending} !== {10'h072, 4'h3, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL b2b_ignored: mpc=%h task=%h sw=%b pend=%b, required 072/3/0/0",
                            mpc, cur_task, switched, pending);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 10'h080, 10'h000, 1'b0, 1'b0, 1'b1, 4'h7);
      cycle(1'b1, 10'h081, 10'h000, 1'b0, 1'b1, 1'b0, 4'h0);
      n_checks++;
      if ({mpc, cur_task, switched, pending} !== {10'h000, 4'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL mid_reset: mpc=%h task=%h sw=%b pend=%b, required 000/0/0/0",
                            mpc, cur_task, switched, pending);
      end
      cycle(1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b1, 4'h7);
      cycle(1'b0, 10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_checks++;
      if (mpc !== 10'h007 || cur_task !== 4'h7) begin
         n_fail++; $display("FAIL reset_slot7: mpc=%h task=%h, required 007/7", mpc, cur_task);
      end
   endtask

   task automatic test_random();
      logic r, st, f1, sk;
      logic [9:0] nf, md;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(99) == 0);
         st = ($urandom_range(4) == 0);
         f1 = ($urandom_range(3) == 0);
         sk = 1'($urandom);
         nf = 10'($urandom);
         md = ($urandom_range(2) == 0) ? 10'($urandom) & 10'h00F : 10'h000;
         cycle(r, nf, md, sk, st, f1, 4'($urandom));
         n_checks++;
         if ({mpc, cur_task, switched, pending} !== {m_mpc, m_task, m_pulse, m_pending}) begin
            n_fail++;
            $display("FAIL random[%0d]: mpc=%h task=%h sw=%b pend=%b, required %h/%h/%b/%b",
                     i, mpc, cur_task, switched, pending, m_mpc, m_task, m_pulse, m_pending);
         end
      end
   endtask

   initial begin
      model_reset();
      rst = 1'b1; next_field = 10'h000; modifiers = 10'h000; skip = 1'b0;
      stall = 1'b0; task_f1 = 1'b0; next_task = 4'h0;
      test_reset();
      test_next_addr();
      test_task_switch();
      test_stall();
      test_same_task();
      test_back_to_back();
      test_reset_mid();
      test_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
